// File: rtl/pool_frame_scheduler_if.sv
// ============================================================================
//  Module  : pool_frame_scheduler_if
//  Brief   : Upstream pixel stream and pooling-datapath signals of the frame
//            scheduler, bundled with scheduler-side and environment modports.
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pool_frame_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INPUT_NUM  = 6
);
    logic                            s_valid;
    logic                            s_ready;
    logic [DATA_WIDTH*INPUT_NUM-1:0] s_data;
    logic                            pool_clr;
    logic                            pool_in_valid;
    logic [DATA_WIDTH*INPUT_NUM-1:0] pool_in_data;
    logic                            pool_out_valid;

    // Environment side: upstream source plus pooling datapath
    modport master (
        output s_valid, s_data, pool_out_valid,
        input  s_ready, pool_clr, pool_in_valid, pool_in_data
    );

    // Scheduler side
    modport slave (
        input  s_valid, s_data, pool_out_valid,
        output s_ready, pool_clr, pool_in_valid, pool_in_data
    );
endinterface

`default_nettype wire

// File: rtl/pool_frame_scheduler.sv
// ============================================================================
//  Module  : pool_frame_scheduler
//  Brief   : Replays one upstream frame per start into the pooling datapath,
//            counts returned results and flags completion/timeout/overflow.
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_frame_scheduler #(
    parameter int DATA_WIDTH    = 16,
    parameter int INPUT_NUM     = 6,
    parameter int INPUT_WIDTH   = 28,
    parameter int WINDOW_WIDTH  = 2,
    parameter int STRIDE        = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    pool_frame_scheduler_if.slave  bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_timeout,
    output logic                   err_overflow
);

    localparam int c_OUT_W  = (INPUT_WIDTH - WINDOW_WIDTH) / STRIDE + 1;
    localparam int c_OUT_N  = c_OUT_W * c_OUT_W;
    localparam int c_TO_W   = $clog2(DRAIN_TIMEOUT + 1);
    localparam int c_DW     = DATA_WIDTH * INPUT_NUM;

    localparam logic [15:0]       c_OUT_NUM   = 16'(c_OUT_N);
    localparam logic [7:0]        c_EDGE_LAST = 8'(INPUT_WIDTH - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_col_cnt;
    logic [7:0]          r_row_cnt;
    logic [15:0]         r_out_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_pool_in_valid;
    logic [c_DW-1:0]     r_pool_in_data;
    logic                r_err_timeout;
    logic                r_err_overflow;

    logic w_accept;
    logic w_hs;
    logic w_last_px;
    logic w_count_out;
    logic w_out_full;
    logic w_timeout;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_hs        = (r_state == ST_FEED) && bus.s_valid;
    assign w_last_px   = (r_col_cnt == c_EDGE_LAST) && (r_row_cnt == c_EDGE_LAST);
    assign w_count_out = (r_state == ST_FEED) || (r_state == ST_DRAIN) || (r_state == ST_DONE);
    assign w_out_full  = (r_out_cnt == c_OUT_NUM);
    // Abort only when the window expires with no result arriving this cycle
    assign w_timeout   = (r_state == ST_DRAIN) && !w_out_full && !bus.pool_out_valid
                         && (r_to_cnt == c_TO_LAST);

    // Every output is a register or a pure decode of the state register
    assign bus.s_ready       = (r_state == ST_FEED);
    assign bus.pool_clr      = (r_state == ST_CLEAR);
    assign bus.pool_in_valid = r_pool_in_valid;
    assign bus.pool_in_data  = r_pool_in_data;
    assign busy              = (r_state != ST_IDLE);
    assign frame_done        = (r_state == ST_DONE);
    assign err_timeout       = r_err_timeout;
    assign err_overflow      = r_err_overflow;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_FEED;
            ST_FEED:  if (w_hs && w_last_px) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_full || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_col_cnt       <= '0;
            r_row_cnt       <= '0;
            r_out_cnt       <= '0;
            r_to_cnt        <= '0;
            r_pool_in_valid <= 1'b0;
            r_pool_in_data  <= '0;
            r_err_timeout   <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pool_in_valid <= w_hs;
            if (w_hs) begin
                r_pool_in_data <= bus.s_data;
            end

            if (w_accept) begin
                r_col_cnt      <= '0;
                r_row_cnt      <= '0;
                r_out_cnt      <= '0;
                r_to_cnt       <= '0;
                r_err_timeout  <= 1'b0;
                r_err_overflow <= 1'b0;
            end else begin
                if (w_hs) begin
                    if (r_col_cnt == c_EDGE_LAST) begin
                        r_col_cnt <= '0;
                        r_row_cnt <= r_row_cnt + 8'd1;
                    end else begin
                        r_col_cnt <= r_col_cnt + 8'd1;
                    end
                end

                // Results saturate; any surplus result is flagged instead
                if (w_count_out && bus.pool_out_valid) begin
                    if (w_out_full) begin
                        r_err_overflow <= 1'b1;
                    end else begin
                        r_out_cnt <= r_out_cnt + 16'd1;
                    end
                end

                if (r_state == ST_DRAIN) begin
                    if (bus.pool_out_valid) begin
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                if (w_timeout) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pool_frame_scheduler.sv
// ============================================================================
//  Module  : tb_pool_frame_scheduler
//  Brief   : Directed self-checking bench for pool_frame_scheduler.
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_frame_scheduler;

    localparam int DW      = 16;
    localparam int IN      = 6;
    localparam int W       = 28;
    localparam int NPX     = W * W;
    localparam int OUT_NUM = 196;
    localparam int TO      = 64;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;
    logic err_timeout;
    logic err_overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int piv_cnt  = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    logic [DW*IN-1:0] q[$];
    logic [DW*IN-1:0] last_data;

    always #5 clk = ~clk;

    pool_frame_scheduler_if #(.DATA_WIDTH(DW), .INPUT_NUM(IN)) bus ();

    pool_frame_scheduler #(
        .DATA_WIDTH   (DW),
        .INPUT_NUM    (IN),
        .INPUT_WIDTH  (W),
        .WINDOW_WIDTH (2),
        .STRIDE       (2),
        .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge index k closes sampled cycle k; state seen after edge k is cycle k+1.
    task automatic tick();
        logic             hs;
        logic [DW*IN-1:0] d;
        hs = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
        if (hs) begin
            q.push_back(bus.s_data);
            hs_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("piv_follows_hs", bus.pool_in_valid, hs);
        if (bus.pool_in_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("piv_without_expected", bus.pool_in_valid, 1'b0);
            end else begin
                d = q.pop_front();
                check("pool_in_data", bus.pool_in_data, d);
                last_data = d;
                piv_cnt++;
            end
        end else begin
            check("pool_in_data_hold", bus.pool_in_data, last_data);
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"},       bus.s_ready,       1'b0);
        check({tag, "_pool_clr"},      bus.pool_clr,      1'b0);
        check({tag, "_pool_in_valid"}, bus.pool_in_valid, 1'b0);
        check({tag, "_pool_in_data"},  bus.pool_in_data,  '0);
        check({tag, "_busy"},          busy,              1'b0);
        check({tag, "_frame_done"},    frame_done,        1'b0);
        check({tag, "_err_timeout"},   err_timeout,       1'b0);
        check({tag, "_err_overflow"},  err_overflow,      1'b0);
    endtask

    // Start a frame and feed stop_at pixels; optional start pulses in CLEAR/FEED
    task automatic run_feed(input bit gapped, input int stop_at,
                            input bit start_in_clear, input int start_at_px);
        hs_cnt = 0;
        start  = 1'b1;
        tick();
        check("clr_pool_clr", bus.pool_clr,  1'b1);
        check("clr_busy",     busy,          1'b1);
        check("clr_s_ready",  bus.s_ready,   1'b0);
        check("clr_err_to",   err_timeout,   1'b0);
        check("clr_err_ov",   err_overflow,  1'b0);
        start = start_in_clear;
        tick();
        check("feed_s_ready",  bus.s_ready,  1'b1);
        check("feed_pool_clr", bus.pool_clr, 1'b0);
        start = 1'b0;
        for (int k = 0; k < 4 * NPX && hs_cnt < stop_at; k++) begin
            bus.s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data  = {IN{16'(hs_cnt)}};
            start       = (hs_cnt == start_at_px);
            tick();
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        check("hs_count",        hs_cnt,       stop_at);
        check("no_extra_clear",  bus.pool_clr, 1'b0);
    endtask

    task automatic strobes(input int n, output int last_edge);
        last_edge = -1;
        for (int i = 0; i < n; i++) begin
            bus.pool_out_valid = 1'b1;
            tick();
            last_edge = cyc;
            bus.pool_out_valid = 1'b0;
            tick();
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && busy === 1'b1; k++) tick();
        check("return_to_idle", busy, 1'b0);
    endtask

    initial begin
        int sc;
        int d0;
        int p0;
        int last_hs;

        rst                = 1'b1;
        start              = 1'b0;
        bus.s_valid        = 1'b0;
        bus.s_data         = '0;
        bus.pool_out_valid = 1'b0;
        last_data          = '0;
        #3;
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Nominal frame
        d0 = done_cnt; p0 = piv_cnt;
        run_feed(1'b0, NPX, 1'b0, -1);
        check("nom_s_ready_drop", bus.s_ready, 1'b0);
        check("nom_busy_drain",   busy,        1'b1);
        strobes(OUT_NUM, sc);
        wait_idle();
        check("nom_done_timing", done_cyc,         sc + 1);
        check("nom_done_count",  done_cnt - d0,    1);
        check("nom_piv_count",   piv_cnt - p0,     NPX);
        check("nom_err_to",      err_timeout,      1'b0);
        check("nom_err_ov",      err_overflow,     1'b0);

        // Gapped input
        d0 = done_cnt; p0 = piv_cnt;
        run_feed(1'b1, NPX, 1'b0, -1);
        check("gap_s_ready_drop", bus.s_ready, 1'b0);
        strobes(OUT_NUM, sc);
        wait_idle();
        check("gap_piv_count",  piv_cnt - p0,  NPX);
        check("gap_done_count", done_cnt - d0, 1);

        // Timeout after 195 results
        d0 = done_cnt;
        run_feed(1'b0, NPX, 1'b0, -1);
        strobes(OUT_NUM - 1, sc);
        wait_idle();
        check("to_done_timing", done_cyc,      sc + TO);
        check("to_done_count",  done_cnt - d0, 1);
        check("to_err_to",      err_timeout,   1'b1);
        check("to_err_ov",      err_overflow,  1'b0);
        repeat (3) tick();
        check("to_err_sticky",  err_timeout,   1'b1);

        // Overflow with 197 results; next start must clear err_timeout
        d0 = done_cnt;
        run_feed(1'b0, NPX, 1'b0, -1);
        strobes(OUT_NUM + 1, sc);
        check("ov_err_ov_set",  err_overflow,  1'b1);
        wait_idle();
        check("ov_done_timing", done_cyc,      sc - 1);
        check("ov_done_count",  done_cnt - d0, 1);
        check("ov_err_to",      err_timeout,   1'b0);
        check("ov_err_sticky",  err_overflow,  1'b1);

        // Asynchronous reset mid-frame
        run_feed(1'b0, 300, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        check_zero("rst_mid");
        last_data = '0;
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("rst_idle", busy, 1'b0);

        d0 = done_cnt; p0 = piv_cnt;
        run_feed(1'b0, NPX, 1'b0, -1);
        strobes(OUT_NUM, sc);
        wait_idle();
        check("post_rst_piv_count",  piv_cnt - p0,  NPX);
        check("post_rst_done_count", done_cnt - d0, 1);
        check("post_rst_done_time",  done_cyc,      sc + 1);

        // Start pulses in CLEAR, FEED, DRAIN and DONE
        d0 = done_cnt;
        run_feed(1'b0, NPX, 1'b1, 400);
        last_hs = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bz_drain_busy",     busy,         1'b1);
        check("bz_drain_pool_clr", bus.pool_clr, 1'b0);
        check("bz_drain_s_ready",  bus.s_ready,  1'b0);
        for (int k = 0; k < 200 && frame_done !== 1'b1; k++) tick();
        check("bz_done_seen",    frame_done,    1'b1);
        check("bz_done_timing",  done_cyc,      last_hs + TO);
        check("bz_err_to_done",  err_timeout,   1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bz_after_done_busy",     busy,         1'b0);
        check("bz_after_done_pool_clr", bus.pool_clr, 1'b0);
        check("bz_after_done_err_to",   err_timeout,  1'b1);
        tick();
        check("bz_idle_busy",     busy,          1'b0);
        check("bz_idle_pool_clr", bus.pool_clr,  1'b0);
        check("bz_done_count",    done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
